// File: rtl/storage_arb_mgmt.sv
// Shared row memory with multiple read channels arbitrated onto one read port (1-cycle latency).
// Define STORAGE_RR_ARB_EN for round-robin arbitration; otherwise the highest requesting index wins.
module storage_arb_mgmt #(
  parameter int READ_ADDR_SIZE = 10,
  parameter int ROW_WIDTH      = 32,
  parameter int AMT_READER     = 4
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [READ_ADDR_SIZE*AMT_READER-1:0] readAddrs,
  input  logic [AMT_READER-1:0]                readReqs,
  input  logic [READ_ADDR_SIZE-1:0]            writeAddr,
  input  logic [ROW_WIDTH-1:0]                 writeData,
  input  logic                                 writeEn,
  output logic [AMT_READER-1:0]                readGrants,
  output logic [AMT_READER-1:0]                readValids,
  output logic [ROW_WIDTH-1:0]                 poolReadData
);

  localparam int DEPTH = 2 ** READ_ADDR_SIZE;
  localparam int IDX_W = $clog2(AMT_READER);

  logic [ROW_WIDTH-1:0]      mem [DEPTH];
  logic                      grant_any;
  logic [IDX_W-1:0]          grant_idx;
  logic [READ_ADDR_SIZE-1:0] rd_addr;
  logic                      wr_hit;
  logic [AMT_READER-1:0]     vld_p1;
  logic [ROW_WIDTH-1:0]      data_p1;
`ifdef STORAGE_RR_ARB_EN
  logic [IDX_W-1:0]          last_grant;
`endif

  always_comb begin
    int cand;
    cand      = 0;
    grant_any = 1'b0;
    grant_idx = '0;
`ifdef STORAGE_RR_ARB_EN
    // Search begins one past the previous winner and wraps around
    for (int k = 1; k <= AMT_READER; k++) begin
      cand = (int'(last_grant) + k) % AMT_READER;
      if (!grant_any && readReqs[cand]) begin
        grant_any = 1'b1;
        grant_idx = IDX_W'(cand);
      end
    end
`else
    for (int i = 0; i < AMT_READER; i++) begin
      if (readReqs[i]) begin
        grant_any = 1'b1;
        grant_idx = IDX_W'(i);
      end
    end
`endif
    if (!rst) grant_any = 1'b0;
  end

  assign readGrants = grant_any ? (AMT_READER'(1) << grant_idx) : '0;
  assign rd_addr    = readAddrs[grant_idx*READ_ADDR_SIZE +: READ_ADDR_SIZE];
  assign wr_hit     = writeEn && (writeAddr == rd_addr);

  always_ff @(posedge clk) begin
    if (rst && writeEn) mem[writeAddr] <= writeData;
  end

  // Stage p1: registered read result, write-first on address collision
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_p1     <= '0;
      data_p1    <= '0;
`ifdef STORAGE_RR_ARB_EN
      last_grant <= IDX_W'(AMT_READER - 1);
`endif
    end else begin
      vld_p1 <= readGrants;
      if (grant_any) begin
        data_p1    <= wr_hit ? writeData : mem[rd_addr];
`ifdef STORAGE_RR_ARB_EN
        last_grant <= grant_idx;
`endif
      end
    end
  end

  assign readValids   = vld_p1;
  assign poolReadData = data_p1;

endmodule

// File: tb/tb_storage_arb_mgmt.sv
// Directed vector bench for storage_arb_mgmt (default parameters, either arbitration mode).
module tb_storage_arb_mgmt;

  logic              clk;
  logic              rst;
  logic [3:0][9:0]   readAddrs;
  logic [3:0]        readReqs;
  logic [9:0]        writeAddr;
  logic [31:0]       writeData;
  logic              writeEn;
  logic [3:0]        readGrants;
  logic [3:0]        readValids;
  logic [31:0]       poolReadData;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    logic [3:0]      reqs;
    logic [3:0][9:0] addrs;
    logic            wen;
    logic [9:0]      waddr;
    logic [31:0]     wdata;
    logic [3:0]      exp_grant;
    logic [31:0]     exp_data;
  } vec_t;

  vec_t vecs [10];

  storage_arb_mgmt dut (
    .clk          (clk),
    .rst          (rst),
    .readAddrs    (readAddrs),
    .readReqs     (readReqs),
    .writeAddr    (writeAddr),
    .writeData    (writeData),
    .writeEn      (writeEn),
    .readGrants   (readGrants),
    .readValids   (readValids),
    .poolReadData (poolReadData)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0; readReqs = '0; writeEn = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    rst = 1'b0; readReqs = '0; readAddrs = '0;
    writeEn = 1'b0; writeAddr = '0; writeData = '0;

    vecs[0] = '{4'b0000, {10'd0, 10'd0, 10'd0, 10'd0}, 1'b1, 10'd5, 32'hA5A5A5A5, 4'b0000, 32'h0};
    vecs[1] = '{4'b0000, {10'd0, 10'd0, 10'd0, 10'd0}, 1'b1, 10'd3, 32'h33333333, 4'b0000, 32'h0};
    vecs[2] = '{4'b0001, {10'd0, 10'd0, 10'd0, 10'd5}, 1'b0, 10'd0, 32'h0, 4'b0001, 32'hA5A5A5A5};
    vecs[3] = '{4'b0000, {10'd0, 10'd0, 10'd0, 10'd0}, 1'b0, 10'd0, 32'h0, 4'b0000, 32'hA5A5A5A5};
    vecs[4] = '{4'b1000, {10'd3, 10'd0, 10'd0, 10'd0}, 1'b0, 10'd0, 32'h0, 4'b1000, 32'h33333333};
    vecs[5] = '{4'b0100, {10'd0, 10'd7, 10'd0, 10'd0}, 1'b1, 10'd7, 32'h12345678, 4'b0100, 32'h12345678};
    vecs[6] = '{4'b0010, {10'd0, 10'd0, 10'd7, 10'd0}, 1'b0, 10'd0, 32'h0, 4'b0010, 32'h12345678};
    vecs[7] = '{4'b0001, {10'd0, 10'd0, 10'd0, 10'd3}, 1'b1, 10'd8, 32'hFFFF0000, 4'b0001, 32'h33333333};
    vecs[8] = '{4'b0001, {10'd0, 10'd0, 10'd0, 10'd8}, 1'b0, 10'd0, 32'h0, 4'b0001, 32'hFFFF0000};
    vecs[9] = '{4'b0000, {10'd0, 10'd0, 10'd0, 10'd0}, 1'b0, 10'd0, 32'h0, 4'b0000, 32'hFFFF0000};

    // Reset state, with requests present
    @(negedge clk);
    readReqs = 4'b1111;
    #2;
    chk("reset_grant", 32'(readGrants), 32'h0);
    chk("reset_valid", 32'(readValids), 32'h0);
    chk("reset_data", poolReadData, 32'h0);
    @(negedge clk);
    readReqs = '0;
    rst = 1'b1;

    for (int i = 0; i < 10; i++) begin
      readReqs  = vecs[i].reqs;
      readAddrs = vecs[i].addrs;
      writeEn   = vecs[i].wen;
      writeAddr = vecs[i].waddr;
      writeData = vecs[i].wdata;
      #2;
      chk($sformatf("vec%0d_grant", i), 32'(readGrants), 32'(vecs[i].exp_grant));
      @(posedge clk); #1;
      chk($sformatf("vec%0d_valid", i), 32'(readValids), 32'(vecs[i].exp_grant));
      chk($sformatf("vec%0d_data", i), poolReadData, vecs[i].exp_data);
      @(negedge clk);
    end

    // Reset pulsed in the cycle after a grant; writes during reset are ignored
    readReqs = 4'b0001; readAddrs = {10'd0, 10'd0, 10'd0, 10'd5};
    writeEn = 1'b1; writeAddr = 10'd9; writeData = 32'h11111111;
    #2;
    chk("rstpulse_grant", 32'(readGrants), 32'h1);
    @(posedge clk); #1;
    rst = 1'b0; readReqs = 4'b1111;
    writeEn = 1'b1; writeAddr = 10'd9; writeData = 32'hDEADBEEF;
    #1;
    chk("rstpulse_valid", 32'(readValids), 32'h0);
    chk("rstpulse_data", poolReadData, 32'h0);
    chk("rstpulse_grant_low", 32'(readGrants), 32'h0);
    repeat (2) begin
      @(posedge clk); #1;
      chk("rst_hold_valid", 32'(readValids), 32'h0);
      chk("rst_hold_data", poolReadData, 32'h0);
    end
    @(negedge clk);
    rst = 1'b1; readReqs = '0; writeEn = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_valid", 32'(readValids), 32'h0);
    chk("post_rst_data", poolReadData, 32'h0);
    @(negedge clk);
    readReqs = 4'b0001; readAddrs = {10'd0, 10'd0, 10'd0, 10'd5};
    @(posedge clk); #1;
    chk("post_rst_mem5", poolReadData, 32'hA5A5A5A5);
    @(negedge clk);
    readAddrs = {10'd0, 10'd0, 10'd0, 10'd9};
    @(posedge clk); #1;
    chk("rst_write_ignored", poolReadData, 32'h11111111);
    @(negedge clk);
    readReqs = '0;

    do_reset();
    readAddrs = {10'd5, 10'd5, 10'd5, 10'd5};
`ifdef STORAGE_RR_ARB_EN
    for (int k = 0; k < 8; k++) begin
      readReqs = 4'b1111;
      #2;
      chk($sformatf("rr%0d_grant", k), 32'(readGrants), 32'(1) << (k % 4));
      @(posedge clk); #1;
      chk($sformatf("rr%0d_valid", k), 32'(readValids), 32'(1) << (k % 4));
      chk($sformatf("rr%0d_data", k), poolReadData, 32'hA5A5A5A5);
      @(negedge clk);
    end
`else
    for (int k = 0; k < 6; k++) begin
      readReqs = 4'b0110;
      #2;
      chk($sformatf("fp%0d_grant", k), 32'(readGrants), 32'h4);
      @(posedge clk); #1;
      chk($sformatf("fp%0d_valid", k), 32'(readValids), 32'h4);
      chk($sformatf("fp%0d_data", k), poolReadData, 32'hA5A5A5A5);
      @(negedge clk);
    end
    for (int k = 0; k < 2; k++) begin
      readReqs = 4'b1111;
      #2;
      chk($sformatf("fp_all%0d_grant", k), 32'(readGrants), 32'h8);
      @(posedge clk); #1;
      chk($sformatf("fp_all%0d_valid", k), 32'(readValids), 32'h8);
      @(negedge clk);
    end
`endif
    readReqs = '0;
    @(posedge clk); #1;
    chk("idle_valid", 32'(readValids), 32'h0);
    chk("idle_data_hold", poolReadData, 32'hA5A5A5A5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
